// File: rtl/isa_pkg.sv
// Shared ISA constants: next-PC select codes, W/ALU codes, opcodes and the fetch state enum.
package isa_pkg;

  localparam logic [1:0] PC_ADD  = 2'd0;
  localparam logic [1:0] PC_WREG = 2'd1;
  localparam logic [1:0] PC_LIT  = 2'd2;
  localparam logic [1:0] PC_SAVE = 2'd3;

  localparam logic [1:0] W_NONE = 2'd0;
  localparam logic [1:0] W_ALU  = 2'd1;
  localparam logic [1:0] W_LIT  = 2'd2;
  localparam logic [1:0] W_MEM  = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SMS = 3'd5;
  localparam logic [2:0] ALU_SMC = 3'd6;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_LDL = 5'h01;
  localparam logic [4:0] OP_ADD = 5'h02;
  localparam logic [4:0] OP_SUB = 5'h03;
  localparam logic [4:0] OP_SMS = 5'h08;
  localparam logic [4:0] OP_SMC = 5'h09;
  localparam logic [4:0] OP_GOW = 5'h0B;
  localparam logic [4:0] OP_GOL = 5'h0C;
  localparam logic [4:0] OP_WFI = 5'h1E;
  localparam logic [4:0] OP_RFI = 5'h1F;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WFI   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/isa_fetch_pc_if.sv
// Instruction-memory fetch bus between the fetch unit (master) and instruction memory (slave).
interface isa_fetch_pc_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 16
);
  // req is held with a stable addr until ack; a word transfers in any cycle where req && ack.
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/isa_pc_shadow.sv
// Shadow PC for wfi/rfi: a single register, or a STACK_DEPTH-entry LIFO when ISA_SHADOW_STACK_EN is defined.
module isa_pc_shadow #(
  parameter int                ADDR_W      = 10,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] wdata,
  output logic [ADDR_W-1:0] rdata
);

`ifdef ISA_SHADOW_STACK_EN
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  // Entry 0 is the top; pushing shifts everything down so the oldest falls off the end.
  logic [ADDR_W-1:0] stack [STACK_DEPTH];
  logic [CNT_W-1:0]  count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (push) begin
      stack[0] <= wdata;
      for (int i = 1; i < STACK_DEPTH; i++) stack[i] <= stack[i-1];
      if (count != CNT_W'(STACK_DEPTH)) count <= count + CNT_W'(1);
    end else if (pop) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) stack[i] <= stack[i+1];
      stack[STACK_DEPTH-1] <= '0;
      if (count != '0) count <= count - CNT_W'(1);
    end
  end

  assign rdata = (count == '0) ? RESET_VEC : stack[0];
`else
  logic [ADDR_W-1:0] shadow_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     shadow_q <= '0;
    else if (push) shadow_q <= wdata;
  end

  // rfi reads the register without clearing it, so pop and the stack parameters have no role here.
  assign rdata = shadow_q;

  logic unused_pop;
  assign unused_pop = pop;
  localparam int                unused_depth     = STACK_DEPTH;
  localparam logic [ADDR_W-1:0] unused_reset_vec = RESET_VEC;
`endif

endmodule

// File: rtl/isa_fetch_pc.sv
// Instruction fetch / program counter: FETCH -> EXEC -> (FETCH | WFI) with wfi/rfi shadow PC.
// Optional LIFO shadow stack enabled by defining ISA_SHADOW_STACK_EN.
module isa_fetch_pc
  import isa_pkg::*;
#(
  parameter int                ADDR_W      = 10,
  parameter int                INSTR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'('h010),
  parameter int                STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  isa_fetch_pc_if.master       imem,
  output logic [4:0]           opcode,
  output logic [INSTR_W-6:0]   literal,
  output logic                 instr_valid,
  input  logic [1:0]           pc_mux,
  input  logic                 pc_save,
  input  logic                 skip,
  input  logic [ADDR_W-1:0]    wreg_target,
  input  logic                 irq,
  output logic [ADDR_W-1:0]    pc,
  output logic                 waiting,
  output fetch_state_t         dbg_state
);

  localparam int LIT_W = INSTR_W - 5;

  fetch_state_t      state;
  logic              req_q;
  logic [ADDR_W-1:0] lit_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] shadow_rdata;
  logic              shadow_push;
  logic              shadow_pop;

  generate
    if (LIT_W >= ADDR_W) begin : g_lit_trunc
      assign lit_pc = literal[ADDR_W-1:0];
    end else begin : g_lit_zext
      assign lit_pc = {{(ADDR_W - LIT_W){1'b0}}, literal};
    end
  endgenerate

  // Sequential successor wraps naturally at ADDR_W bits.
  assign pc_inc = pc + (skip ? ADDR_W'(2) : ADDR_W'(1));

  assign shadow_push = (state == ST_EXEC) && (pc_mux == PC_SAVE) && pc_save;
  assign shadow_pop  = (state == ST_EXEC) && (pc_mux == PC_SAVE) && !pc_save;

  isa_pc_shadow #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH),
    .RESET_VEC   (RESET_VEC)
  ) u_shadow (
    .clk   (clk),
    .reset (reset),
    .push  (shadow_push),
    .pop   (shadow_pop),
    .wdata (pc + ADDR_W'(1)),
    .rdata (shadow_rdata)
  );

  // req is registered, so the first FETCH cycle after reset has req low and ignores any stale ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_VEC;
      opcode      <= '0;
      literal     <= '0;
      instr_valid <= 1'b0;
      req_q       <= 1'b0;
      waiting     <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (req_q && imem.ack) begin
            opcode      <= imem.rdata[INSTR_W-1 -: 5];
            literal     <= imem.rdata[LIT_W-1:0];
            instr_valid <= 1'b1;
            req_q       <= 1'b0;
            state       <= ST_EXEC;
          end else begin
            req_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          req_q <= 1'b1;
          case (pc_mux)
            PC_ADD:  pc <= pc_inc;
            PC_WREG: pc <= wreg_target;
            PC_LIT:  pc <= lit_pc;
            default: begin
              if (pc_save) begin
                state   <= ST_WFI;
                req_q   <= 1'b0;
                waiting <= 1'b1;
              end else begin
                pc <= shadow_rdata;
              end
            end
          endcase
        end
        ST_WFI: begin
          if (irq) begin
            pc      <= IRQ_VEC;
            waiting <= 1'b0;
            req_q   <= 1'b1;
            state   <= ST_FETCH;
          end
        end
        default: begin
          state   <= ST_FETCH;
          req_q   <= 1'b0;
          waiting <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req  = req_q;
  assign imem.addr = pc;
  assign dbg_state = state;

endmodule

// File: tb/tb_isa_fetch_pc.sv
// Directed bench for isa_fetch_pc: sequential fetch, wait states, wrap, gow/gol, wfi/rfi, reset abort, shadow stack.
module tb_isa_fetch_pc;
  import isa_pkg::*;

  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 16;

`ifdef ISA_SHADOW_STACK_EN
  localparam logic [9:0] EXP_RFI2 = 10'h021;
  localparam logic [9:0] EXP_RFI3 = 10'h000;
`else
  localparam logic [9:0] EXP_RFI2 = 10'h031;
  localparam logic [9:0] EXP_RFI3 = 10'h031;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [4:0]        opcode;
  logic [10:0]       literal;
  logic              instr_valid;
  logic [1:0]        pc_mux = 2'd0;
  logic              pc_save = 1'b0;
  logic              skip = 1'b0;
  logic [9:0]        wreg_target = '0;
  logic              irq = 1'b0;
  logic [9:0]        pc;
  logic              waiting;
  fetch_state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  isa_fetch_pc_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem_bus ();

  isa_fetch_pc #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_bus),
    .opcode      (opcode),
    .literal     (literal),
    .instr_valid (instr_valid),
    .pc_mux      (pc_mux),
    .pc_save     (pc_save),
    .skip        (skip),
    .wreg_target (wreg_target),
    .irq         (irq),
    .pc          (pc),
    .waiting     (waiting),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_req();
    int n = 0;
    while (imem_bus.req !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("req_rise", 32'(imem_bus.req), 32'd1);
  endtask

  // Entered at a negedge in FETCH with req high; returns at the negedge after EXEC.
  task automatic fetch_exec(input logic [9:0] exp_addr, input logic [15:0] instr, input int waits,
                            input logic [1:0] mux, input logic sv, input logic skp,
                            input logic [9:0] wreg);
    for (int i = 0; i < waits; i++) begin
      imem_bus.ack = 1'b0;
      chk("req_hold", 32'(imem_bus.req), 32'd1);
      chk("addr_hold", 32'(imem_bus.addr), 32'(exp_addr));
      chk("no_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = instr;
    chk("req", 32'(imem_bus.req), 32'd1);
    chk("addr", 32'(imem_bus.addr), 32'(exp_addr));
    @(negedge clk);
    imem_bus.ack = 1'b0;
    chk("valid", 32'(instr_valid), 32'd1);
    chk("opcode", 32'(opcode), 32'(instr[15:11]));
    chk("literal", 32'(literal), 32'(instr[10:0]));
    chk("pc_stable", 32'(pc), 32'(exp_addr));
    chk("req_exec", 32'(imem_bus.req), 32'd0);
    pc_mux      = mux;
    pc_save     = sv;
    skip        = skp;
    wreg_target = wreg;
    @(negedge clk);
    chk("valid_drop", 32'(instr_valid), 32'd0);
    pc_mux  = PC_ADD;
    pc_save = 1'b0;
    skip    = 1'b0;
  endtask

  // Entered at the first WFI negedge; idles, pulses irq and confirms the wake to IRQ_VEC.
  task automatic wfi_wake(input int idle);
    for (int i = 0; i < idle; i++) begin
      chk("waiting", 32'(waiting), 32'd1);
      chk("wfi_no_req", 32'(imem_bus.req), 32'd0);
      chk("wfi_state", 32'(dbg_state), 32'(ST_WFI));
      @(negedge clk);
    end
    irq = 1'b1;
    chk("waiting_irq", 32'(waiting), 32'd1);
    @(negedge clk);
    irq = 1'b0;
    chk("woke", 32'(waiting), 32'd0);
    chk("irq_vec", 32'(pc), 32'h010);
    chk("wake_req", 32'(imem_bus.req), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 32'h000);
    chk("rst_req", 32'(imem_bus.req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_waiting", 32'(waiting), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_literal", 32'(literal), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_FETCH));
    reset = 1'b0;
    wait_req();

    // Zero-wait sequential fetch, then jump to the top of the address space.
    fetch_exec(10'h000, 16'h0801, 0, PC_ADD,  1'b0, 1'b0, 10'h000);
    fetch_exec(10'h001, 16'h1002, 0, PC_ADD,  1'b0, 1'b0, 10'h000);
    fetch_exec(10'h002, 16'h5803, 0, PC_WREG, 1'b0, 1'b0, 10'h3FF);
    // Three wait states, then ADD+skip wraps 3FF -> 001.
    fetch_exec(10'h3FF, 16'h4455, 3, PC_ADD,  1'b0, 1'b1, 10'h000);
    fetch_exec(10'h001, 16'h4000, 0, PC_ADD,  1'b0, 1'b1, 10'h000);
    fetch_exec(10'h003, 16'h5800, 0, PC_WREG, 1'b0, 1'b0, 10'h005);
    fetch_exec(10'h005, 16'h6123, 0, PC_LIT,  1'b0, 1'b0, 10'h000);
    fetch_exec(10'h123, 16'h5800, 0, PC_WREG, 1'b0, 1'b0, 10'h020);

    // wfi at 020, wake to 010, rfi back to 021.
    fetch_exec(10'h020, 16'hF000, 0, PC_SAVE, 1'b1, 1'b0, 10'h000);
    wfi_wake(3);
    fetch_exec(10'h010, 16'hF800, 0, PC_SAVE, 1'b0, 1'b0, 10'h000);
    // skip must not affect a literal jump.
    fetch_exec(10'h021, 16'h6040, 0, PC_LIT,  1'b0, 1'b1, 10'h000);
    fetch_exec(10'h040, 16'h0000, 0, PC_ADD,  1'b0, 1'b0, 10'h000);

    // irq high through FETCH/EXEC is ignored, then wakes on the first WFI cycle.
    irq = 1'b1;
    fetch_exec(10'h041, 16'hF000, 1, PC_SAVE, 1'b1, 1'b0, 10'h000);
    chk("wfi_min", 32'(waiting), 32'd1);
    @(negedge clk);
    irq = 1'b0;
    chk("wfi_min_wake", 32'(waiting), 32'd0);
    chk("wfi_min_pc", 32'(pc), 32'h010);
    fetch_exec(10'h010, 16'hF800, 0, PC_SAVE, 1'b0, 1'b0, 10'h000);

    // Reset while a fetch at 042 is awaiting ack; the held ack must not be captured.
    imem_bus.ack = 1'b0;
    chk("pre_rst_addr", 32'(imem_bus.addr), 32'h042);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = 16'hABCD;
    #2 reset = 1'b1;
    #1;
    chk("abort_req", 32'(imem_bus.req), 32'd0);
    chk("abort_pc", 32'(pc), 32'h000);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("stale_valid", 32'(instr_valid), 32'd0);
    chk("stale_opcode", 32'(opcode), 32'd0);
    chk("post_rst_addr", 32'(imem_bus.addr), 32'h000);
    imem_bus.ack = 1'b0;
    wait_req();

    // Nested wfi at 020 and 030 followed by three rfi.
    fetch_exec(10'h000, 16'h5800, 0, PC_WREG, 1'b0, 1'b0, 10'h020);
    fetch_exec(10'h020, 16'hF000, 0, PC_SAVE, 1'b1, 1'b0, 10'h000);
    wfi_wake(1);
    fetch_exec(10'h010, 16'h5800, 0, PC_WREG, 1'b0, 1'b0, 10'h030);
    fetch_exec(10'h030, 16'hF000, 0, PC_SAVE, 1'b1, 1'b0, 10'h000);
    wfi_wake(1);
    fetch_exec(10'h010, 16'hF800, 0, PC_SAVE, 1'b0, 1'b0, 10'h000);
    fetch_exec(10'h031, 16'h5800, 0, PC_WREG, 1'b0, 1'b0, 10'h010);
    fetch_exec(10'h010, 16'hF800, 0, PC_SAVE, 1'b0, 1'b0, 10'h000);
    fetch_exec(EXP_RFI2, 16'h5800, 0, PC_WREG, 1'b0, 1'b0, 10'h010);
    fetch_exec(10'h010, 16'hF800, 0, PC_SAVE, 1'b0, 1'b0, 10'h000);
    fetch_exec(EXP_RFI3, 16'h0000, 0, PC_ADD,  1'b0, 1'b0, 10'h000);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/isa_fetch_pc.md
Name: isa_fetch_pc

Overview:
- Instruction-fetch and program-counter unit: the producer side of the opcode interface that drives the instruction decoder, and the consumer of its pc_mux/pc_save controls.
- Fetches instruction words from instruction memory and splits each into a 5-bit opcode and a literal.
- Issues each instruction for one execute cycle, then computes the next PC. Next-PC sources: sequential (with ALU skip), W register, literal, or shadow-PC save/restore for wfi/rfi.
- Sits between instruction memory and the decoder/ALU datapath.

Parameters:
- ADDR_W, 10, PC and instruction-memory address width.
- INSTR_W, 16, instruction word width; opcode = [INSTR_W-1:INSTR_W-5], literal = [INSTR_W-6:0].
- RESET_VEC, 0, PC loaded on reset.
- IRQ_VEC, 'h010, PC loaded on wake from wfi.
- STACK_DEPTH, 4, shadow entries; used only with ISA_SHADOW_STACK_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request, held until acknowledged.
- imem_addr  out  ADDR_W  fetch address (= pc while imem_req is high).
- imem_ack  in  1  read data valid; may be asserted in the same cycle as imem_req.
- imem_rdata  in  INSTR_W  instruction word, sampled when imem_req && imem_ack.
- opcode  out  5  registered opcode, to the decoder.
- literal  out  INSTR_W-5  registered literal field.
- instr_valid  out  1  one-cycle pulse marking the execute cycle.
- pc_mux  in  2  from decoder: 0=ADD, 1=WREG, 2=LIT, 3=SAVE.
- pc_save  in  1  from decoder: 1=wfi (save and wait), 0 with SAVE=rfi (restore).
- skip  in  1  ALU skip result (sms/smc), meaningful only in the execute cycle.
- wreg_target  in  ADDR_W  W register value used for gow.
- irq  in  1  level-sensitive wake request.
- pc  out  ADDR_W  current program counter.
- waiting  out  1  high while in WFI.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - pc=RESET_VEC, state=FETCH.
  - opcode=0, literal=0, instr_valid=0, imem_req=0, waiting=0, shadow=0.
  - An in-flight fetch is abandoned; imem_ack is ignored until FETCH is re-entered.
- States: FETCH, EXEC, WFI.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: latch opcode/literal from imem_rdata, go to EXEC. With zero-wait memory an instruction completes every 2 cycles.
- EXEC:
  - instr_valid=1 for exactly this cycle.
  - pc_mux, pc_save and skip are sampled at the end of the cycle. Next PC:
    - ADD: pc+1, or pc+2 if skip=1.
    - WREG: wreg_target.
    - LIT: literal[ADDR_W-1:0], zero-extended when the literal is narrower than ADDR_W.
    - SAVE with pc_save=1: shadow<=pc+1, go to WFI.
    - SAVE with pc_save=0: pc<=shadow, go to FETCH.
  - All other cases go to FETCH.
  - skip is ignored unless pc_mux=ADD.
- WFI:
  - waiting=1, imem_req=0.
  - On a cycle with irq=1: pc<=IRQ_VEC, go to FETCH.
  - irq already high when WFI is entered wakes on the first WFI cycle; WFI therefore lasts at least 1 cycle.
- irq is ignored in FETCH and EXEC.
- All PC arithmetic wraps modulo 2^ADDR_W (pc='h3FF with ADD gives 0; with skip gives 1).
- pc is stable in FETCH and EXEC; it updates only on the EXEC->FETCH or WFI->FETCH edge.

Optional Feature:
- Macro: ISA_SHADOW_STACK_EN.
- Defined: shadow is a STACK_DEPTH-entry LIFO.
  - wfi pushes pc+1; rfi pops.
  - Push when full discards the oldest entry.
  - Pop when empty yields RESET_VEC.
- Undefined: single shadow register; each wfi overwrites it, and rfi reads it without clearing.

Decomposition:
- Shared package isa_pkg holds:
  - PC_ADD/PC_WREG/PC_LIT/PC_SAVE codes.
  - W_* and ALU_* codes.
  - 5-bit opcode constants.
  - Fetch state enum (FETCH/EXEC/WFI).
- One sub-module, isa_pc_shadow: single register, or LIFO under ISA_SHADOW_STACK_EN, with push/pop/rdata ports.

Test Plan:
- Reset, then zero-wait memory returning sequential instructions, pc_mux=0 -> imem_addr 0,1,2; instr_valid pulses every 2nd cycle.
- Memory ack delayed 3 cycles -> imem_req/imem_addr held for 3 cycles; exactly one instr_valid pulse; opcode/literal match imem_rdata.
- Execute at pc='h3FF with pc_mux=0, skip=1 -> next fetch address 'h001. Execute at pc=5 with pc_mux=2, literal='h123 -> next fetch address 'h123.
- wfi at pc='h020 (pc_mux=3, pc_save=1) -> waiting=1, no fetch; irq pulse -> fetch at 'h010; later rfi -> fetch at 'h021.
- Reset asserted while in FETCH awaiting ack -> imem_req drops immediately; after release, first fetch at RESET_VEC; stale ack ignored.
- ISA_SHADOW_STACK_EN: two nested wfi at 'h020 and 'h030, then two rfi -> fetch 'h031 then 'h021; a third rfi -> fetch at RESET_VEC.
